// File: rtl/add_sub_post_norm.sv
// Single-precision add/sub back end: mantissa add/subtract, normalize, round, pack.
// Two register stages, one result per cycle, fixed latency of two clocks.
module add_sub_post_norm (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  rmode,
  input  logic [26:0] fracta,
  input  logic [26:0] fractb,
  input  logic [7:0]  exp_dn,
  input  logic        sign,
  input  logic        fasu_op,
  input  logic        nan_in,
  input  logic        result_zero_sign,
  input  logic        nan_sign,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  typedef enum logic [1:0] {
    RM_NEAREST = 2'd0,
    RM_ZERO    = 2'd1,
    RM_POS     = 2'd2,
    RM_NEG     = 2'd3
  } rmode_t;

  logic        s1_valid;
  logic [27:0] s1_sum;
  logic [7:0]  s1_exp;
  logic        s1_sign;
  logic        s1_nan;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_exp   <= '0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_sum   <= fasu_op ? ({1'b0, fracta} + {1'b0, fractb})
                          : ({1'b0, fracta} - {1'b0, fractb});
      s1_exp   <= exp_dn;
      s1_sign  <= sign;
      s1_nan   <= nan_in;
    end
  end

  logic signed [9:0] e_eff, e_norm, e_fin;
  logic [4:0]        lz, shamt;
  logic [26:0]       m;
  logic              g, r, st, inx, inc, to_inf;
  logic [24:0]       mant_r;
  logic [23:0]       mant_f;
  logic [7:0]        exp_field;
  logic [31:0]       res_c;
  logic              ov_c, uf_c, ix_c;

  always_comb begin
    e_eff     = (s1_exp == 8'd0) ? 10'sd1 : $signed({2'b00, s1_exp});
    lz        = 5'd27;
    shamt     = '0;
    m         = '0;
    e_norm    = e_eff;
    inc       = 1'b0;
    to_inf    = 1'b0;
    res_c     = '0;
    ov_c      = 1'b0;
    uf_c      = 1'b0;
    ix_c      = 1'b0;

    // Ascending scan: the highest set bit is the last to write lz.
    for (int unsigned i = 0; i < 27; i++) begin
      if (s1_sum[i]) lz = 5'(26 - i);
    end

    if (s1_sum[27]) begin
      m      = {s1_sum[27:2], s1_sum[1] | s1_sum[0]};
      e_norm = e_eff + 10'sd1;
    end else begin
      // Shift is capped so the exponent never drops below 1 (denormal floor).
      if ($signed({5'b00000, lz}) < (e_eff - 10'sd1)) shamt = lz;
      else                                              shamt = e_eff[4:0] - 5'd1;
      m      = s1_sum[26:0] << shamt;
      e_norm = e_eff - $signed({5'b00000, shamt});
    end

    g   = m[2];
    r   = m[1];
    st  = m[0];
    inx = g | r | st;

    case (rmode_t'(rmode))
      RM_NEAREST: inc = g & (r | st | m[3]);
      RM_ZERO:    inc = 1'b0;
      RM_POS:     inc = inx & ~s1_sign;
      RM_NEG:     inc = inx & s1_sign;
      default:    inc = 1'b0;
    endcase

    mant_r = {1'b0, m[26:3]} + {24'b0, inc};
    if (mant_r[24]) begin
      mant_f = 24'h800000;
      e_fin  = e_norm + 10'sd1;
    end else begin
      mant_f = mant_r[23:0];
      e_fin  = e_norm;
    end
    exp_field = mant_f[23] ? e_fin[7:0] : 8'd0;

    case (rmode_t'(rmode))
      RM_NEAREST: to_inf = 1'b1;
      RM_POS:     to_inf = ~s1_sign;
      RM_NEG:     to_inf = s1_sign;
      default:    to_inf = 1'b0;
    endcase

    if (s1_nan) begin
      res_c = {nan_sign, 8'hFF, 1'b1, 22'b0};
    end else if (s1_exp == 8'hFF) begin
      res_c = {s1_sign, 8'hFF, 23'b0};
    end else if (s1_sum == '0) begin
      res_c = {result_zero_sign, 31'b0};
    end else if (e_fin >= 10'sd255) begin
      ov_c  = 1'b1;
      ix_c  = 1'b1;
      res_c = to_inf ? {s1_sign, 8'hFF, 23'b0} : {s1_sign, 31'h7F7FFFFF};
    end else begin
      ix_c  = inx;
      uf_c  = inx & (exp_field == 8'd0);
      res_c = {s1_sign, exp_field, mant_f[22:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      result    <= res_c;
      overflow  <= ov_c;
      underflow <= uf_c;
      inexact   <= ix_c;
    end
  end

endmodule
